// File: rtl/button_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_bank
// Description : Bank of N independent push-button conditioners. Each channel
//               synchronises its raw input, debounces press and release, and
//               emits a press pulse (with optional auto-repeat), a debounced
//               level and a release pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_bank #(
    parameter int N         = 4,
    parameter int DEBOUNCE  = 4,
    parameter int REPEAT_EN = 1,
    parameter int HOLD      = 8,
    parameter int REPEAT    = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] Bi,
    output logic [N-1:0] Bo,
    output logic [N-1:0] Level,
    output logic [N-1:0] Rel
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_HELD   = 2'd2,
        ST_DISARM = 2'd3
    } state_t;

    // Debounce counter holds 0..DEBOUNCE-1; repeat counter covers the longer
    // of the two repeat intervals.
    localparam int c_dcw  = $clog2(DEBOUNCE + 1);
    localparam int c_rmax = (HOLD > REPEAT) ? HOLD : REPEAT;
    localparam int c_rcw  = $clog2(c_rmax + 1);

    localparam logic [c_dcw-1:0] c_deb_last  = c_dcw'(DEBOUNCE - 1);
    localparam logic [c_dcw-1:0] c_deb_one   = c_dcw'(1);
    localparam logic [c_rcw-1:0] c_hold_last = c_rcw'(HOLD - 1);
    localparam logic [c_rcw-1:0] c_rep_last  = c_rcw'(REPEAT - 1);

    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;

    // Two-flop synchroniser on the raw button inputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= Bi;
            r_s2 <= r_s1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        state_t             r_state;
        state_t             w_state_nxt;
        logic [c_dcw-1:0]   r_dcnt;
        logic [c_dcw-1:0]   w_dcnt_nxt;
        logic [c_rcw-1:0]   r_rcnt;
        logic [c_rcw-1:0]   w_rcnt_nxt;
        logic               r_rphase;
        logic               w_rphase_nxt;
        logic               r_bo;
        logic               r_level;
        logic               r_rel;
        logic               w_bo_nxt;
        logic               w_rel_nxt;
        logic               w_s;

        assign w_s = r_s2[i];

        // Next-state, counter and pulse decode for one channel
        always_comb begin
            w_state_nxt  = r_state;
            w_dcnt_nxt   = '0;
            w_rcnt_nxt   = '0;
            w_rphase_nxt = 1'b0;
            w_bo_nxt     = 1'b0;
            w_rel_nxt    = 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_s) begin
                        if (DEBOUNCE == 1) begin
                            w_state_nxt = ST_HELD;
                            w_bo_nxt    = 1'b1;
                        end else begin
                            w_state_nxt = ST_ARM;
                            w_dcnt_nxt  = c_deb_one;
                        end
                    end
                end
                ST_ARM: begin
                    if (!w_s) begin
                        // Glitch shorter than the debounce window: drop it
                        w_state_nxt = ST_IDLE;
                    end else if (r_dcnt == c_deb_last) begin
                        w_state_nxt = ST_HELD;
                        w_bo_nxt    = 1'b1;
                    end else begin
                        w_dcnt_nxt  = r_dcnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!w_s) begin
                        if (DEBOUNCE == 1) begin
                            w_state_nxt = ST_IDLE;
                            w_rel_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_DISARM;
                            w_dcnt_nxt  = c_deb_one;
                        end
                    end
                end
                ST_DISARM: begin
                    if (w_s) begin
                        // Release bounce: back to held silently
                        w_state_nxt = ST_HELD;
                    end else if (r_dcnt == c_deb_last) begin
                        w_state_nxt = ST_IDLE;
                        w_rel_nxt   = 1'b1;
                    end else begin
                        w_dcnt_nxt  = r_dcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            // Auto-repeat runs only while the channel stays in HELD; any other
            // state clears it so a re-entry restarts the HOLD interval.
            if ((REPEAT_EN != 0) && (r_state == ST_HELD) && (w_state_nxt == ST_HELD)) begin
                if ((!r_rphase && (r_rcnt == c_hold_last)) ||
                    ( r_rphase && (r_rcnt == c_rep_last))) begin
                    w_bo_nxt     = 1'b1;
                    w_rcnt_nxt   = '0;
                    w_rphase_nxt = 1'b1;
                end else begin
                    w_rcnt_nxt   = r_rcnt + 1'b1;
                    w_rphase_nxt = r_rphase;
                end
            end
        end

        // Channel state, counters and registered outputs
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_state  <= ST_IDLE;
                r_dcnt   <= '0;
                r_rcnt   <= '0;
                r_rphase <= 1'b0;
                r_bo     <= 1'b0;
                r_level  <= 1'b0;
                r_rel    <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_dcnt   <= w_dcnt_nxt;
                r_rcnt   <= w_rcnt_nxt;
                r_rphase <= w_rphase_nxt;
                r_bo     <= w_bo_nxt;
                r_level  <= (w_state_nxt == ST_HELD) || (w_state_nxt == ST_DISARM);
                r_rel    <= w_rel_nxt;
            end
        end

        assign Bo[i]    = r_bo;
        assign Level[i] = r_level;
        assign Rel[i]   = r_rel;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce_bank
// Description : Directed self-checking bench for button_debounce_bank with
//               N=4, DEBOUNCE=4, REPEAT_EN=1, HOLD=8, REPEAT=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce_bank;

    logic       Clk;
    logic       Reset;
    logic [3:0] Bi;
    logic [3:0] Bo;
    logic [3:0] Level;
    logic [3:0] Rel;

    int total = 0;
    int bad   = 0;

    button_debounce_bank #(
        .N         (4),
        .DEBOUNCE  (4),
        .REPEAT_EN (1),
        .HOLD      (8),
        .REPEAT    (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Bi    (Bi),
        .Bo    (Bo),
        .Level (Level),
        .Rel   (Rel)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input int t,
                       input logic [3:0] ebo, input logic [3:0] elev, input logic [3:0] erel);
        total++;
        assert ({Bo, Level, Rel} === {ebo, elev, erel}) else begin
            bad++;
            $error("FAIL %s t=%0d observed Bo=%b Level=%b Rel=%b expected Bo=%b Level=%b Rel=%b",
                   tag, t, Bo, Level, Rel, ebo, elev, erel);
        end
    endtask

    initial begin
        logic [3:0] ebo;
        logic [3:0] elev;
        logic [3:0] erel;

        Reset = 1'b1;
        Bi    = 4'b0000;
        repeat (3) tick();
        chk("reset", 0, 4'b0000, 4'b0000, 4'b0000);
        Reset = 1'b0;
        tick();
        tick();
        chk("idle", 0, 4'b0000, 4'b0000, 4'b0000);

        // Channel 0: press at edge k (t=0), repeats, a 2-cycle release bounce
        // at t=22..23 (HELD re-entered at t=26), then clean release from t=39.
        for (int t = 0; t <= 46; t++) begin
            Bi[0] = (t <= 38) && !(t == 22 || t == 23);
            tick();
            ebo  = (t == 5 || t == 13 || t == 17 || t == 21 || t == 34 || t == 38) ? 4'b0001 : 4'b0000;
            elev = (t >= 5 && t <= 43) ? 4'b0001 : 4'b0000;
            erel = (t == 44) ? 4'b0001 : 4'b0000;
            chk("ch0_press_hold_release", t, ebo, elev, erel);
        end

        // Channel 1: 3-cycle glitch must be rejected
        for (int t = 0; t <= 9; t++) begin
            Bi[1] = (t < 3);
            tick();
            chk("ch1_glitch", t, 4'b0000, 4'b0000, 4'b0000);
        end

        // Channels 3:2 pressed together; channel 0 joins at t=8
        for (int t = 0; t <= 15; t++) begin
            Bi[3:2] = 2'b11;
            Bi[0]   = (t >= 8);
            tick();
            ebo  = ((t == 5 || t == 13) ? 4'b1100 : 4'b0000) | ((t == 13) ? 4'b0001 : 4'b0000);
            elev = ((t >= 5) ? 4'b1100 : 4'b0000) | ((t >= 13) ? 4'b0001 : 4'b0000);
            chk("simul_press", t, ebo, elev, 4'b0000);
        end

        // Reset while three channels are held: outputs drop, no release pulse
        Reset = 1'b1;
        tick();
        chk("reset_mid_hold", 0, 4'b0000, 4'b0000, 4'b0000);
        Reset = 1'b0;

        // Inputs still held are re-debounced as fresh presses from edge j (t=0)
        for (int t = 0; t <= 6; t++) begin
            tick();
            ebo  = (t == 5) ? 4'b1101 : 4'b0000;
            elev = (t >= 5) ? 4'b1101 : 4'b0000;
            chk("repress_after_reset", t, ebo, elev, 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_debounce_bank.md
BUTTON_DEBOUNCE_BANK -- requirements
Module: button_debounce_bank

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of independent button channels (1..32).
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, giving the consecutive stable synchronised samples required to accept a level change (>=1).
REQ-003 The block SHALL have parameter REPEAT_EN, default 1, where 1 enables auto-repeat press pulses and 0 disables them.
REQ-004 The block SHALL have parameter HOLD, default 8, giving the cycles from the press pulse to the first repeat pulse (>=2).
REQ-005 The block SHALL have parameter REPEAT, default 4, giving the cycles between subsequent repeat pulses (>=2).
REQ-006 The block SHALL have port Clk, input, 1 bit, the single system clock; all state SHALL update on posedge Clk.
REQ-007 The block SHALL have port Reset, input, 1 bit, a synchronous active-high reset.
REQ-008 The block SHALL have port Bi, input, N bits, the raw asynchronous button inputs, 1 = pressed.
REQ-009 The block SHALL have port Bo, output, N bits, one-cycle press pulses per channel, including repeat pulses.
REQ-010 The block SHALL have port Level, output, N bits, the debounced pressed level per channel.
REQ-011 The block SHALL have port Rel, output, N bits, one-cycle release pulses per channel.

Function
REQ-012 Each channel SHALL pass Bi[i] through two flops (s1 then s2), and only s2 SHALL feed channel logic.
REQ-013 Each channel SHALL run an FSM with states IDLE, ARM, HELD and DISARM, plus a debounce counter and a repeat counter sized with $clog2.
REQ-014 In IDLE, s2=1 SHALL move the channel to ARM with count=1 (or directly to HELD if DEBOUNCE=1), and s2=0 SHALL keep it in IDLE with count=0.
REQ-015 In ARM, s2=1 SHALL increment count, and the DEBOUNCE-th consecutive high sample SHALL enter HELD with Bo[i]=1 for exactly the next cycle.
REQ-016 In ARM, s2=0 SHALL return the channel to IDLE with count cleared and no output change (glitch rejected).
REQ-017 Press latency SHALL be as follows: Bi first sampled high at edge k gives Bo[i] and Level[i] high after edge k+1+DEBOUNCE.
REQ-018 Level[i] SHALL be 1 in HELD and DISARM and 0 in IDLE and ARM, and SHALL be registered.
REQ-019 In HELD, s2=0 SHALL enter DISARM, and DEBOUNCE consecutive low samples SHALL return the channel to IDLE with Rel[i]=1 for one cycle and Level[i] falling on the same edge.
REQ-020 In DISARM, s2=1 SHALL return the channel to HELD with count cleared, with no Rel[i] and no new press pulse.
REQ-021 When REPEAT_EN=1, a channel that has been continuously in HELD SHALL pulse Bo[i] HOLD cycles after entering HELD, then every REPEAT cycles.
REQ-022 The repeat counter SHALL clear whenever the state is not HELD, so a return from DISARM restarts the HOLD interval.
REQ-023 When REPEAT_EN=0, exactly one Bo[i] pulse SHALL occur per accepted press.
REQ-024 Bo[i] and Rel[i] SHALL never both be 1 in the same cycle, and neither SHALL exceed one cycle per event.
REQ-025 Channels SHALL be fully independent, so simultaneous events on several channels assert their bits in the same cycle.
REQ-026 The unused state encoding SHALL go to IDLE on the next edge with all outputs 0.

Reset
REQ-027 Reset=1 at a posedge SHALL clear s1, s2, all states (to IDLE), all counters, Bo, Level and Rel to 0 on that edge, with priority over all other logic.
REQ-028 Reset mid-press or mid-hold SHALL drop outputs on the next edge and produce no Rel pulse.
REQ-029 After Reset deasserts, an input still held SHALL be re-debounced as a new press.

Verification (N=4, DEBOUNCE=4, REPEAT_EN=1, HOLD=8, REPEAT=4)
REQ-030 The bench SHALL cover a clean press: Bi[0] sampled high at edge k and held -> Bo[0] single-cycle pulses after edges k+5, k+13, k+17, k+21, with Level[0]=1 from edge k+5.
REQ-031 The bench SHALL cover glitch rejection: Bi[1] high for 3 cycles -> Bo[1], Level[1] and Rel[1] stay 0 throughout.
REQ-032 The bench SHALL cover a clean release: Bi[0] sampled low at edge m after a hold -> Level[0]=0 and a one-cycle Rel[0] pulse after edge m+5.
REQ-033 The bench SHALL cover a release bounce: Bi[0] low for 2 cycles during a hold -> no Rel[0], Level[0] stays 1, no extra Bo[0], and the next repeat pulse comes 8 cycles after HELD re-entry.
REQ-034 The bench SHALL cover a simultaneous press: Bi[3:2] high at the same edge k -> Bo[3:2]=2'b11 in the same cycle after edge k+5.
REQ-035 The bench SHALL cover reset mid-hold: Reset=1 for one edge while Bi[0]=1 -> all outputs 0 on that edge, and a fresh Bo[0] pulse after edge j+5, where j is the first edge with Reset=0.
